teamplayer_io: RTL

//  Four-pad multitap sequencer on one controller port. Serializes the pads into the host's nibble stream.

---
 rtl/teamplayer_io.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/teamplayer_io.sv
`default_nettype none
// ============================================================================
// teamplayer_io : four-pad multitap sequencer that serializes pads into the
//                 host nibble stream (TH start/abort, TR/TL handshake).
// Option macro  : TEAMPLAYER_HOTPLUG_EN adds present_i (per-pad presence).
// Revision      : 1.0 - initial release
// ============================================================================
module teamplayer_io #(
    parameter int unsigned ACK_DLY = 8,
    parameter logic [3:0]  END_NIB = 4'hF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ce_i,
    input  logic [47:0] pads_i,
    input  logic [3:0]  pad6_i,
`ifdef TEAMPLAYER_HOTPLUG_EN
    input  logic [3:0]  present_i,
`endif
    input  logic [7:0]  di_i,
    output logic [7:0]  do_o,
    output logic        busy_o
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_ACTIVE  = 1'b1;
    localparam logic [7:0] C_ACK_LAST = 8'(ACK_DLY - 1);

    logic [0:0]  state_q, state_d;
    logic        th_q, th_prev_q, tr_q;
    logic        tl_q, tl_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [47:0] snap_pads_q;
    logic [3:0]  snap_six_q, snap_pres_q;
    logic [7:0]  do_q, do_d;

    logic        w_th_fall, w_th_rise, w_pending;
    logic [3:0]  w_present;
    logic [3:0]  w_data [12];
    logic [3:0]  w_type [4];
    logic [3:0]  w_len;
    logic [4:0]  w_off;
    logic [3:0]  w_nib;
    logic        w_unused_di;

`ifdef TEAMPLAYER_HOTPLUG_EN
    assign w_present = present_i;
`else
    assign w_present = 4'hF;
`endif

    assign w_unused_di = ^{di_i[7], di_i[4:0]};

    // Edges are taken between two sampled TH values, giving one CE of input latency.
    assign w_th_fall = th_prev_q & ~th_q;
    assign w_th_rise = ~th_prev_q & th_q;
    assign w_pending = (tr_q != tl_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tl_d    = tl_q;
        cnt_d   = cnt_q;
        if (w_th_rise) begin
            state_d = ST_IDLE;
            idx_d   = 5'd0;
            tl_d    = 1'b1;
            cnt_d   = 8'd0;
        end else if (w_th_fall) begin
            state_d = ST_ACTIVE;
            idx_d   = 5'd0;
            tl_d    = 1'b1;
            cnt_d   = 8'd0;
        end else if (state_q == ST_ACTIVE) begin
            if (w_pending) begin
                if (cnt_q == C_ACK_LAST) begin
                    idx_d = (idx_q == 5'd31) ? idx_q : idx_q + 5'd1;
                    tl_d  = tr_q;
                    cnt_d = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end else begin
                cnt_d = 8'd0;
            end
        end
    end

    // Data nibbles packed from the snapshot; absent pads leave no gap.
    always_comb begin
        logic [3:0]  pos;
        logic [11:0] p;
        pos    = 4'd0;
        p      = 12'd0;
        w_data = '{default: END_NIB};
        for (int n = 0; n < 4; n++) begin
            p = snap_pads_q[12*n +: 12];
            w_type[n] = !snap_pres_q[n] ? 4'hF : (snap_six_q[n] ? 4'h1 : 4'h0);
            if (snap_pres_q[n]) begin
                w_data[pos]        = p[3:0];
                w_data[pos + 4'd1] = {p[7], p[4], p[6], p[5]};
                if (snap_six_q[n]) begin
                    w_data[pos + 4'd2] = {p[8], p[9], p[10], p[11]};
                    pos = pos + 4'd3;
                end else begin
                    pos = pos + 4'd2;
                end
            end
        end
        w_len = pos;
    end

    always_comb begin
        w_off = idx_d - 5'd8;
        w_nib = END_NIB;
        if (state_d == ST_IDLE) begin
            w_nib = 4'h3;
        end else if (idx_d < 5'd8) begin
            case (idx_d[2:0])
                3'd0:       w_nib = 4'h3;
                3'd1:       w_nib = 4'hF;
                3'd2, 3'd3: w_nib = 4'h0;
                default:    w_nib = w_type[idx_d[1:0]];
            endcase
        end else if (w_off < {1'b0, w_len}) begin
            w_nib = w_data[w_off[3:0]];
        end
    end

    assign do_d = {1'b0, di_i[6], 1'b1, tl_d, w_nib};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            th_q        <= 1'b1;
            th_prev_q   <= 1'b1;
            tr_q        <= 1'b1;
            tl_q        <= 1'b1;
            idx_q       <= 5'd0;
            cnt_q       <= 8'd0;
            snap_pads_q <= '1;
            snap_six_q  <= 4'hF;
            snap_pres_q <= 4'hF;
            do_q        <= 8'h73;
        end else if (ce_i) begin
            th_q      <= di_i[6];
            th_prev_q <= th_q;
            tr_q      <= di_i[5];
            state_q   <= state_d;
            tl_q      <= tl_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            do_q      <= do_d;
            if (w_th_fall && !w_th_rise) begin
                snap_pads_q <= pads_i;
                snap_six_q  <= pad6_i;
                snap_pres_q <= w_present;
            end
        end
    end

    assign do_o   = do_q;
    assign busy_o = (state_q == ST_ACTIVE);

endmodule
`default_nettype wire
